// File: rtl/switch_conditioner_if.sv
// Switch conditioner bus: raw switch levels and frame tick in, conditioned levels and edge pulses out.
interface switch_conditioner_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] raw;
  logic             frame_tick;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output raw, frame_tick,
    input  level, rise, fall, changed
  );

  modport slave (
    input  raw, frame_tick,
    output level, rise, fall, changed
  );
endinterface

// File: rtl/switch_conditioner.sv
// Synchronise, debounce and frame-align the raw switch inputs (SWITCH_CONDITIONER_FRAME_ALIGN_EN: release at frame_tick).
// Latency: 2 sync cycles + 2^COUNT_BITS sample ticks + release; no backpressure, outputs are free-running levels/pulses.
module switch_conditioner #(
  parameter int               WIDTH         = 8,
  parameter int               PRESCALE_BITS = 10,
  parameter int               COUNT_BITS    = 2,
  parameter logic [WIDTH-1:0] RESET_LEVEL   = {WIDTH{1'b0}}
) (
  input logic            clk,
  input logic            rst,
  switch_conditioner_if.slave bus
);
  typedef enum logic {IDLE, COUNTING} deb_state_e;

  localparam logic [COUNT_BITS-1:0] CNT_MAX = {COUNT_BITS{1'b1}};

  logic [WIDTH-1:0]                 meta;
  logic [WIDTH-1:0]                 sync;
  logic [PRESCALE_BITS-1:0]         prescale;
  logic                             sample_tick;
  logic [WIDTH-1:0][COUNT_BITS-1:0] cnt;
  logic [WIDTH-1:0][COUNT_BITS-1:0] cnt_next;
  logic [WIDTH-1:0]                 deb;
  logic [WIDTH-1:0]                 deb_next;
  deb_state_e                       state [WIDTH];
  logic [WIDTH-1:0]                 level;
  logic [WIDTH-1:0]                 level_next;
  logic [WIDTH-1:0]                 rise;
  logic [WIDTH-1:0]                 fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_LEVEL;
      sync <= RESET_LEVEL;
    end else begin
      meta <= bus.raw;
      sync <= meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign sample_tick = &prescale;

  // Any agreeing sample drops the bit back to IDLE, so a glitch must not interrupt the run.
  always_comb begin
    cnt_next = cnt;
    deb_next = deb;
    for (int i = 0; i < WIDTH; i++) begin
      state[i] = (cnt[i] == '0) ? IDLE : COUNTING;
      if (sample_tick) begin
        case (state[i])
          IDLE: begin
            if (sync[i] != deb[i]) begin
              cnt_next[i] = cnt[i] + 1'b1;
            end
          end
          COUNTING: begin
            if (sync[i] == deb[i]) begin
              cnt_next[i] = '0;
            end else if (cnt[i] == CNT_MAX) begin
              deb_next[i] = sync[i];
              cnt_next[i] = '0;
            end else begin
              cnt_next[i] = cnt[i] + 1'b1;
            end
          end
          default: cnt_next[i] = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      deb <= RESET_LEVEL;
    end else begin
      cnt <= cnt_next;
      deb <= deb_next;
    end
  end

`ifdef SWITCH_CONDITIONER_FRAME_ALIGN_EN
  assign level_next = bus.frame_tick ? deb : level;
`else
  logic unused_frame_tick;
  assign unused_frame_tick = bus.frame_tick;
  assign level_next = deb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= RESET_LEVEL;
      rise  <= '0;
      fall  <= '0;
    end else begin
      level <= level_next;
      rise  <= level_next & ~level;
      fall  <= ~level_next & level;
    end
  end

  assign bus.level   = level;
  assign bus.rise    = rise;
  assign bus.fall    = fall;
  assign bus.changed = |{rise, fall};
endmodule

// File: tb/tb_switch_conditioner.sv
// Directed scoreboard bench for switch_conditioner with PRESCALE_BITS=2, COUNT_BITS=2 (sample every 4 cycles, 4 samples to flip).
`timescale 1ns/1ps
module tb_switch_conditioner;
  localparam int W = 8;
`ifdef SWITCH_CONDITIONER_FRAME_ALIGN_EN
  localparam bit FA = 1'b1;
`else
  localparam bit FA = 1'b0;
`endif

  typedef struct {
    int           cyc;
    logic [W-1:0] level;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc;
  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  switch_conditioner_if #(.WIDTH(W)) sif ();

  switch_conditioner #(
    .WIDTH        (W),
    .PRESCALE_BITS(2),
    .COUNT_BITS   (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(sif)
  );

  always #5 clk = ~clk;

  // Edge index since the last reset release; edge k leaves the prescaler at k mod 4.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int c, input logic [W-1:0] lv, input logic [W-1:0] r, input logic [W-1:0] f);
    exp_t e;
    e.cyc = c; e.level = lv; e.rise = r; e.fall = f;
    sb.push_back(e);
  endtask

  task automatic step_to(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) check("step_timeout", cyc, n);
  endtask

  task automatic frame_pulse(input int t);
    step_to(t - 1);
    sif.frame_tick = 1'b1;
    step_to(t);
    sif.frame_tick = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst && (sif.changed !== 1'b0 || sif.rise !== '0 || sif.fall !== '0)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: cycle %0d level=%h rise=%h fall=%h changed=%b, expected no pulse",
                 cyc, sif.level, sif.rise, sif.fall, sif.changed);
      end else begin
        e = sb.pop_front();
        check("evt_cycle",   cyc,         e.cyc);
        check("evt_level",   sif.level,   e.level);
        check("evt_rise",    sif.rise,    e.rise);
        check("evt_fall",    sif.fall,    e.fall);
        check("evt_changed", sif.changed, 1'b1);
      end
    end
  end

  initial begin
    sif.raw        = 8'hFF;
    sif.frame_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_level",   sif.level,   8'h00);
    check("rst_rise",    sif.rise,    8'h00);
    check("rst_fall",    sif.fall,    8'h00);
    check("rst_changed", sif.changed, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // raw=FF held through reset: flips at edge 16; the frame tick on edge 16 collides and misses it.
    push(FA ? 20 : 17, 8'hFF, 8'hFF, 8'h00);
    step_to(8);
    check("post_rst_level_c8", sif.level, 8'h00);
    frame_pulse(16);
    step_to(17);
    sif.raw = 8'h00;
    push(FA ? 36 : 33, 8'h00, 8'h00, 8'hFF);
    step_to(18);
    check("collision_hold_rise", sif.level, FA ? 8'h00 : 8'hFF);
    frame_pulse(20);

    // Fall flips at edge 32, colliding again; then a 3-cycle frame_tick gives one pulse only.
    frame_pulse(32);
    step_to(34);
    check("collision_hold_fall", sif.level, FA ? 8'hFF : 8'h00);
    step_to(35);
    sif.frame_tick = 1'b1;
    step_to(38);
    sif.frame_tick = 1'b0;
    step_to(40);
    check("held_tick_level", sif.level, 8'h00);

    step_to(41);
    sif.raw = 8'h01;
    push(FA ? 60 : 57, 8'h01, 8'h01, 8'h00);
    frame_pulse(60);

    // raw[3] high for 10 cycles: three samples agree, the fourth does not, so no flip.
    step_to(65);
    sif.raw = 8'h09;
    step_to(75);
    sif.raw = 8'h01;
    frame_pulse(84);
    step_to(88);
    check("glitch_level", sif.level, 8'h01);

    step_to(89);
    sif.raw = 8'h00;
    push(FA ? 108 : 105, 8'h00, 8'h00, 8'h01);
    frame_pulse(108);

    step_to(113);
    sif.raw = 8'hA5;
    push(FA ? 132 : 129, 8'hA5, 8'hA5, 8'h00);
    frame_pulse(132);
    step_to(136);
    check("multi_level", sif.level, 8'hA5);

    step_to(137);
    sif.raw = 8'h5A;
    push(FA ? 156 : 153, 8'h5A, 8'h5A, 8'hA5);
    frame_pulse(156);

    // Flip and flip back between frame ticks: visible only when release is not frame-aligned.
    step_to(161);
    sif.raw = 8'h5B;
    if (!FA) push(177, 8'h5B, 8'h01, 8'h00);
    step_to(177);
    sif.raw = 8'h5A;
    if (!FA) push(193, 8'h5A, 8'h00, 8'h01);
    frame_pulse(196);
    step_to(200);
    check("flipback_level", sif.level, 8'h5A);

    // Reset mid-count clears everything at once and emits nothing afterwards.
    step_to(201);
    sif.raw = 8'h00;
    step_to(209);
    rst = 1'b1;
    #1;
    check("async_rst_level",   sif.level,   8'h00);
    check("async_rst_rise",    sif.rise,    8'h00);
    check("async_rst_fall",    sif.fall,    8'h00);
    check("async_rst_changed", sif.changed, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (24) @(negedge clk);
    check("final_level", sif.level, 8'h00);
    check("scoreboard_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
